// File: rtl/ud_ctrl_pkg.sv
// Shared types and default timing constants for the up/down button front-end.
// The FSM state encoding lives here so the bench and the RTL agree on it.
package ud_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD_UP = 2'd1,
        HOLD_DN = 2'd2,
        LOCK    = 2'd3
    } state_t;

    localparam int DEF_DB_CNT   = 4;
    localparam int DEF_REP_DLY  = 50;
    localparam int DEF_REP_RATE = 10;
    localparam int DEF_CW       = 8;

endpackage

// File: rtl/ud_button_ctrl_if.sv
// Button/command bundle between the panel-side driver and the button controller.
// master drives the strobe and raw buttons; slave returns commands and levels.
interface ud_button_ctrl_if;

    logic tick;
    logic btn_up;
    logic btn_dn;
    logic up;
    logic down;
    logic up_db;
    logic dn_db;

    modport master (
        output tick, btn_up, btn_dn,
        input  up, down, up_db, dn_db
    );

    modport slave (
        input  tick, btn_up, btn_dn,
        output up, down, up_db, dn_db
    );

endinterface

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchronizer followed by a tick-paced debounce counter.
// db flips only after DB_CNT consecutive ticks on which sync disagrees with it.
module btn_debounce #(
    parameter int DB_CNT = 4,
    parameter int CW     = 8
) (
    input  logic clk_ref,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic db
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

    logic          meta;
    logic          sync;
    logic          db_q;
    logic [CW-1:0] cnt;

    // NOTE: every register here uses <= so all flops sample pre-edge values.
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            db_q <= 1'b0;
            cnt  <= '0;
        end else begin
            meta <= btn;
            sync <= meta;
            if (tick) begin
                if (sync == db_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    db_q <= ~db_q;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign db = db_q;

endmodule

// File: rtl/ud_button_ctrl.sv
// Turns two debounced buttons into single-cycle up/down command pulses with
// hold-to-auto-repeat; pressing both (in any order) locks out commands.
module ud_button_ctrl
    import ud_ctrl_pkg::*;
#(
    parameter int DB_CNT   = DEF_DB_CNT,
    parameter int REP_DLY  = DEF_REP_DLY,
    parameter int REP_RATE = DEF_REP_RATE,
    parameter int CW       = DEF_CW
) (
    input  logic             clk_ref,
    input  logic             rst,
    ud_button_ctrl_if.slave  bus
);

    localparam logic [CW-1:0] DLY_LIM  = CW'(REP_DLY);
    localparam logic [CW-1:0] RATE_LIM = CW'(REP_RATE);
    localparam bit            REP_EN   = (REP_DLY != 0);

    logic up_db;
    logic dn_db;
    logic up_prev;
    logic dn_prev;
    logic press_up;
    logic press_dn;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] rep_cnt_q;
    logic [CW-1:0] rep_cnt_d;
    logic [CW-1:0] rep_nxt;
    logic [CW-1:0] rep_lim;
    logic          rpt_q;
    logic          rpt_d;
    logic          up_q;
    logic          up_d;
    logic          down_q;
    logic          down_d;

    btn_debounce #(.DB_CNT(DB_CNT), .CW(CW)) u_db_up (
        .clk_ref (clk_ref),
        .rst     (rst),
        .tick    (bus.tick),
        .btn     (bus.btn_up),
        .db      (up_db)
    );

    btn_debounce #(.DB_CNT(DB_CNT), .CW(CW)) u_db_dn (
        .clk_ref (clk_ref),
        .rst     (rst),
        .tick    (bus.tick),
        .btn     (bus.btn_dn),
        .db      (dn_db)
    );

    assign press_up = up_db & ~up_prev;
    assign press_dn = dn_db & ~dn_prev;

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q   <= IDLE;
            rep_cnt_q <= '0;
            rpt_q     <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            up_prev   <= 1'b0;
            dn_prev   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            rpt_q     <= rpt_d;
            up_q      <= up_d;
            down_q    <= down_d;
            up_prev   <= up_db;
            dn_prev   <= dn_db;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        rpt_d     = rpt_q;
        up_d      = 1'b0;
        down_d    = 1'b0;
        rep_nxt   = rep_cnt_q + 1'b1;
        rep_lim   = rpt_q ? RATE_LIM : DLY_LIM;

        case (state_q)
            IDLE: begin
                // A second button joining, or both at once, is ambiguous: refuse it.
                if ((press_up && press_dn) || (press_up && dn_db) || (press_dn && up_db)) begin
                    state_d = LOCK;
                end else if (press_up) begin
                    up_d      = 1'b1;
                    state_d   = HOLD_UP;
                    rep_cnt_d = '0;
                    rpt_d     = 1'b0;
                end else if (press_dn) begin
                    down_d    = 1'b1;
                    state_d   = HOLD_DN;
                    rep_cnt_d = '0;
                    rpt_d     = 1'b0;
                end
            end

            HOLD_UP: begin
                if (!up_db) begin
                    state_d = IDLE;
                end else if (dn_db) begin
                    state_d = LOCK;
                end else if (REP_EN && bus.tick) begin
                    if (rep_nxt == rep_lim) begin
                        up_d      = 1'b1;
                        rep_cnt_d = '0;
                        rpt_d     = 1'b1;
                    end else begin
                        rep_cnt_d = rep_nxt;
                    end
                end
            end

            HOLD_DN: begin
                if (!dn_db) begin
                    state_d = IDLE;
                end else if (up_db) begin
                    state_d = LOCK;
                end else if (REP_EN && bus.tick) begin
                    if (rep_nxt == rep_lim) begin
                        down_d    = 1'b1;
                        rep_cnt_d = '0;
                        rpt_d     = 1'b1;
                    end else begin
                        rep_cnt_d = rep_nxt;
                    end
                end
            end

            LOCK: begin
                if (!up_db && !dn_db) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.up    = up_q;
    assign bus.down  = down_q;
    assign bus.up_db = up_db;
    assign bus.dn_db = dn_db;

endmodule
